// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register file bank.
//   regfile_state_e : INIT (post-reset zeroing sweep) / RUN (normal access)
//   REGFILE_*       : default data width, register count and address width
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } regfile_state_e;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_REGS   = 32;
  localparam int REGFILE_ADDR_W = 5;

endpackage

// File: rtl/regfile_init_ctrl.sv
// regfile_init_ctrl: INIT/RUN sequencer for register_file_bank.
// After reset it walks init_ptr over every register, asking the array to
// write zero there, then switches to RUN and raises Ready.
// Ports:
//   Clock     - rising-edge clock
//   Reset     - synchronous, active-low reset
//   run       - 1 while in RUN (user reads/writes enabled)
//   init_we   - sweep write strobe (only with Reset high)
//   init_addr - register being zeroed by the sweep
//   Ready     - registered, 1 once the sweep has finished
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int NrOfRegs = REGFILE_REGS,
  parameter int AddrBits = REGFILE_ADDR_W
) (
  input  logic                Clock,
  input  logic                Reset,
  output logic                run,
  output logic                init_we,
  output logic [AddrBits-1:0] init_addr,
  output logic                Ready
);

  localparam logic [AddrBits-1:0] LAST_ADDR = AddrBits'(NrOfRegs - 1);

  regfile_state_e      state_r, state_s;
  logic [AddrBits-1:0] init_ptr_r, init_ptr_s;
  logic                ready_r, ready_s;

  // State register: sweep pointer, state and Ready, synchronous reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r    <= INIT;
      init_ptr_r <= {AddrBits{1'b0}};
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      init_ptr_r <= init_ptr_s;
      ready_r    <= ready_s;
    end
  end

  // Next-state logic: advance the sweep, leave INIT after the last register.
  always_comb begin
    state_s    = state_r;
    init_ptr_s = init_ptr_r;
    ready_s    = ready_r;
    case (state_r)
      INIT: begin
        init_ptr_s = init_ptr_r + {{(AddrBits-1){1'b0}}, 1'b1};
        if (init_ptr_r == LAST_ADDR) begin
          state_s = RUN;
          ready_s = 1'b1;
        end else begin
          state_s = INIT;
          ready_s = 1'b0;
        end
      end
      RUN: begin
        state_s = RUN;
        ready_s = 1'b1;
      end
      default: begin
        state_s    = INIT;
        init_ptr_s = {AddrBits{1'b0}};
        ready_s    = 1'b0;
      end
    endcase
  end

  // Output logic: sweep strobe is suppressed on reset edges.
  always_comb begin
    run       = 1'b0;
    init_we   = 1'b0;
    init_addr = init_ptr_r;
    case (state_r)
      INIT: begin
        run     = 1'b0;
        init_we = Reset;
      end
      RUN: begin
        run     = 1'b1;
        init_we = 1'b0;
      end
      default: begin
        run     = 1'b0;
        init_we = 1'b0;
      end
    endcase
  end

  assign Ready = ready_r;

endmodule

// File: rtl/register_file_bank.sv
// register_file_bank: NrOfRegs x NrOfBits register file, one write port and
// two asynchronous read ports. Storage has no per-bit reset; a zeroing sweep
// after reset clears it, so it can map onto RAM primitives.
// Ports:
//   Clock, Reset (sync, active-low)
//   ClockEnable & Tick - write qualifiers
//   cs                 - 1 tri-states RdDataA/RdDataB
//   WrEn, WrAddr, WrData
//   RdAddrA/RdDataA, RdAddrB/RdDataB - combinational read ports
//   Ready              - 1 once the zeroing sweep is done
// Build option: define REGFILE_BYPASS_EN to forward a qualified same-cycle
// write to a read port addressing the same register.
module register_file_bank
  import regfile_pkg::*;
#(
  parameter int NrOfBits = REGFILE_DATA_W,
  parameter int NrOfRegs = REGFILE_REGS,
  parameter int AddrBits = REGFILE_ADDR_W,
  parameter int ZeroReg  = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                cs,
  input  logic                WrEn,
  input  logic [AddrBits-1:0] WrAddr,
  input  logic [NrOfBits-1:0] WrData,
  input  logic [AddrBits-1:0] RdAddrA,
  input  logic [AddrBits-1:0] RdAddrB,
  output logic [NrOfBits-1:0] RdDataA,
  output logic [NrOfBits-1:0] RdDataB,
  output logic                Ready
);

  localparam logic [AddrBits:0] REG_COUNT = (AddrBits + 1)'(NrOfRegs);

  // An address refers to real storage: in range and not the hardwired zero.
  function automatic logic addr_valid(input logic [AddrBits-1:0] addr);
    return ({1'b0, addr} < REG_COUNT) &&
           !((ZeroReg != 0) && (addr == {AddrBits{1'b0}}));
  endfunction

  logic [NrOfBits-1:0] mem_r [NrOfRegs];

  logic                run_s;
  logic                init_we_s;
  logic [AddrBits-1:0] init_addr_s;
  logic                user_we_s;
  logic                mem_we_s;
  logic [AddrBits-1:0] mem_addr_s;
  logic [NrOfBits-1:0] mem_data_s;
  logic [NrOfBits-1:0] rd_a_s;
  logic [NrOfBits-1:0] rd_b_s;

  regfile_init_ctrl #(
    .NrOfRegs (NrOfRegs),
    .AddrBits (AddrBits)
  ) u_init_ctrl (
    .Clock     (Clock),
    .Reset     (Reset),
    .run       (run_s),
    .init_we   (init_we_s),
    .init_addr (init_addr_s),
    .Ready     (Ready)
  );

  // A reset edge must not also commit a user write.
  assign user_we_s = Reset & run_s & WrEn & ClockEnable & Tick & addr_valid(WrAddr);

  // Write-port mux: sweep zeroes take the port while in INIT.
  always_comb begin
    if (init_we_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = init_addr_s;
      mem_data_s = {NrOfBits{1'b0}};
    end else begin
      mem_we_s   = user_we_s;
      mem_addr_s = WrAddr;
      mem_data_s = WrData;
    end
  end

  // Storage array write, no reset so it can be inferred as RAM.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_data_s;
    end
  end

  // Read port A: masked in INIT, zero/out-of-range rules before forwarding.
  always_comb begin
    rd_a_s = {NrOfBits{1'b0}};
    if (run_s && addr_valid(RdAddrA)) begin
`ifdef REGFILE_BYPASS_EN
      if (user_we_s && (RdAddrA == WrAddr)) begin
        rd_a_s = WrData;
      end else begin
        rd_a_s = mem_r[RdAddrA];
      end
`else
      rd_a_s = mem_r[RdAddrA];
`endif
    end else begin
      rd_a_s = {NrOfBits{1'b0}};
    end
  end

  // Read port B: same rules as port A, forwarded independently.
  always_comb begin
    rd_b_s = {NrOfBits{1'b0}};
    if (run_s && addr_valid(RdAddrB)) begin
`ifdef REGFILE_BYPASS_EN
      if (user_we_s && (RdAddrB == WrAddr)) begin
        rd_b_s = WrData;
      end else begin
        rd_b_s = mem_r[RdAddrB];
      end
`else
      rd_b_s = mem_r[RdAddrB];
`endif
    end else begin
      rd_b_s = {NrOfBits{1'b0}};
    end
  end

  assign RdDataA = cs ? {NrOfBits{1'bz}} : rd_a_s;
  assign RdDataB = cs ? {NrOfBits{1'bz}} : rd_b_s;

endmodule

// File: tb/tb_register_file_bank.sv
// Testbench for register_file_bank: two instances share stimulus
// (32 regs with hardwired zero, 24 regs without). Read buses are weakly
// pulled high so a tri-stated port reads as all ones.
module tb_register_file_bank;

  logic        clock = 1'b0;
  logic        reset_n, clock_enable, tick, cs, wr_en;
  logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data;
  tri1  [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        ready0, ready1;

  int checks   = 0;
  int failures = 0;

  // Reference model: per instance, an array plus "ready after N edges".
  logic [31:0] mdl_mem [2][32];
  int          mdl_n   [2];
  bit          mdl_z   [2];
  bit          mdl_ready [2];
  int          mdl_cnt [2];

  always #5 clock = ~clock;

  register_file_bank #(.NrOfBits(32), .NrOfRegs(32), .AddrBits(5), .ZeroReg(1)) dut0 (
    .Clock(clock), .Reset(reset_n), .ClockEnable(clock_enable), .Tick(tick), .cs(cs),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .RdAddrA(rd_addr_a), .RdAddrB(rd_addr_b),
    .RdDataA(rd_a0), .RdDataB(rd_b0), .Ready(ready0));

  register_file_bank #(.NrOfBits(32), .NrOfRegs(24), .AddrBits(5), .ZeroReg(0)) dut1 (
    .Clock(clock), .Reset(reset_n), .ClockEnable(clock_enable), .Tick(tick), .cs(cs),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .RdAddrA(rd_addr_a), .RdAddrB(rd_addr_b),
    .RdDataA(rd_a1), .RdDataB(rd_b1), .Ready(ready1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_qualified(int d);
    return mdl_ready[d] && reset_n && wr_en && clock_enable && tick &&
           (int'(wr_addr) < mdl_n[d]) && !(mdl_z[d] && wr_addr == 5'd0);
  endfunction

  function automatic logic [31:0] mdl_read(int d, logic [4:0] a);
    if (!mdl_ready[d]) return 32'h0;
    if ((int'(a) >= mdl_n[d]) || (mdl_z[d] && a == 5'd0)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (mdl_qualified(d) && a == wr_addr) return wr_data;
`endif
    return mdl_mem[d][a];
  endfunction

  task automatic mdl_edge();
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        mdl_ready[d] = 1'b0;
        mdl_cnt[d]   = 0;
      end else if (!mdl_ready[d]) begin
        mdl_cnt[d]++;
        if (mdl_cnt[d] == mdl_n[d]) begin
          mdl_ready[d] = 1'b1;
          for (int i = 0; i < 32; i++) mdl_mem[d][i] = 32'h0;
        end
      end else if (mdl_qualified(d)) begin
        mdl_mem[d][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ready0", {31'd0, ready0}, {31'd0, mdl_ready[0]});
    chk("ready1", {31'd0, ready1}, {31'd0, mdl_ready[1]});
    chk($sformatf("rd_a0[%0d]", rd_addr_a), rd_a0, cs ? 32'hFFFF_FFFF : mdl_read(0, rd_addr_a));
    chk($sformatf("rd_b0[%0d]", rd_addr_b), rd_b0, cs ? 32'hFFFF_FFFF : mdl_read(0, rd_addr_b));
    chk($sformatf("rd_a1[%0d]", rd_addr_a), rd_a1, cs ? 32'hFFFF_FFFF : mdl_read(1, rd_addr_a));
    chk($sformatf("rd_b1[%0d]", rd_addr_b), rd_b1, cs ? 32'hFFFF_FFFF : mdl_read(1, rd_addr_b));
  endtask

  // Called at posedge+1 with inputs set: check pre-edge outputs, take the edge.
  task automatic step();
    #4;
    check_outputs();
    @(posedge clock);
    mdl_edge();
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] v);
    wr_en = 1'b1; wr_addr = a; wr_data = v; clock_enable = 1'b1; tick = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic sweep_reads();
    wr_en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a);
      rd_addr_b = 5'(31 - a);
      step();
    end
  endtask

  initial begin
    int ready_edges;
    mdl_n[0] = 32; mdl_z[0] = 1'b1;
    mdl_n[1] = 24; mdl_z[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mdl_ready[d] = 1'b0;
      mdl_cnt[d]   = 0;
      for (int i = 0; i < 32; i++) mdl_mem[d][i] = 32'h0;
    end
    reset_n = 1'b0; clock_enable = 1'b0; tick = 1'b0; cs = 1'b0; wr_en = 1'b0;
    wr_addr = 5'd0; wr_data = 32'h0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;

    // Reset held for two edges.
    @(posedge clock); mdl_edge(); #1;
    @(posedge clock); mdl_edge(); #1;
    chk("ready_in_reset", {31'd0, ready0}, 32'd0);

    // Sweep with a write to addr 5 requested throughout (must be ignored).
    reset_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE_F00D; clock_enable = 1'b1; tick = 1'b1;
    ready_edges = 0;
    for (int i = 0; i < 40; i++) begin
      rd_addr_a = 5'($urandom_range(0, 31));
      rd_addr_b = 5'($urandom_range(0, 31));
      step();
      if (ready0) begin
        ready_edges = i + 1;
        break;
      end
    end
    chk("ready_latency", 32'(ready_edges), 32'd32);
    wr_en = 1'b0;
    rd_addr_a = 5'd5; #1;
    chk("init_write_dropped", rd_a0, 32'h0);

    // Basic write, then a Tick=0 write that must be dropped.
    write(5'd7, 32'hDEAD_BEEF);
    rd_addr_a = 5'd7; #1;
    chk("write_7", rd_a0, 32'hDEAD_BEEF);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0BAD_0BAD; tick = 1'b0;
    step();
    wr_en = 1'b0; tick = 1'b1; #1;
    chk("tick0_dropped", rd_a0, 32'hDEAD_BEEF);

    // Register 0: hardwired zero on dut0, ordinary on dut1.
    write(5'd0, 32'h1234_5678);
    rd_addr_a = 5'd0; rd_addr_b = 5'd0; #1;
    chk("zero_reg_a", rd_a0, 32'h0);
    chk("zero_reg_b", rd_b0, 32'h0);
    chk("plain_reg0", rd_a1, 32'h1234_5678);

    // Addr 30: valid on dut0, out of range on dut1.
    write(5'd30, 32'h5555_AAAA);
    rd_addr_a = 5'd30; #1;
    chk("oor_dropped", rd_a1, 32'h0);
    chk("addr30_dut0", rd_a0, 32'h5555_AAAA);
    sweep_reads();

    // Chip select tri-states reads only.
    rd_addr_a = 5'd7; rd_addr_b = 5'd7; cs = 1'b1; #1;
    chk("cs_z_a", rd_a0, 32'hFFFF_FFFF);
    chk("cs_z_b", rd_b0, 32'hFFFF_FFFF);
    step();
    chk("cs_ready", {31'd0, ready0}, 32'd1);
    cs = 1'b0; #1;
    chk("cs_release", rd_a0, 32'hDEAD_BEEF);

    // Same-cycle write/read of addr 9.
    write(5'd9, 32'h1111_1111);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_A5A5; rd_addr_a = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_9", rd_a0, 32'hA5A5_A5A5);
`else
    chk("no_bypass_9", rd_a0, 32'h1111_1111);
`endif
    step();
    wr_en = 1'b0; #1;
    chk("after_9", rd_a0, 32'hA5A5_A5A5);

    // Fill 1..31, reset mid-RUN for one edge, full sweep, all zero.
    for (int a = 1; a < 32; a++) write(5'(a), $urandom());
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("ready_after_reset", {31'd0, ready0}, 32'd0);
    for (int i = 0; i < 32; i++) step();
    chk("ready_resweep", {31'd0, ready0}, 32'd1);
    sweep_reads();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      clock_enable = ($urandom_range(0, 7) != 0);
      tick         = ($urandom_range(0, 7) != 0);
      cs           = ($urandom_range(0, 7) == 0);
      wr_en        = $urandom_range(0, 1) != 0;
      wr_addr      = 5'($urandom_range(0, 31));
      wr_data      = $urandom();
      rd_addr_a    = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b    = 5'($urandom_range(0, 31));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_bank.md
Name: register_file_bank

Overview:
Parametrised multi-register storage bank, the successor to the single flip-flop register. Used as the integer register file of the single-cycle RISC-V core.
- NrOfRegs words of NrOfBits each; one write port, two asynchronous read ports.
- Write qualification uses ClockEnable&Tick; cs tri-states the read outputs.
- A sequential init sweep zeroes the array after reset, so the storage maps to RAM primitives instead of a per-bit reset.

Parameters:
NrOfBits, 32, data width of each register
NrOfRegs, 32, number of registers (>=2)
AddrBits, 5, address width; must satisfy 2**AddrBits >= NrOfRegs
ZeroReg, 1, 1 = register 0 hardwired to zero (writes dropped, reads 0); 0 = register 0 is ordinary

Ports:
Clock  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-low reset
ClockEnable  input  1  write qualifier, ANDed with Tick
Tick  input  1  write qualifier, ANDed with ClockEnable
cs  input  1  1 = RdDataA/RdDataB driven to all-Z; 0 = driven
WrEn  input  1  write request
WrAddr  input  AddrBits  write address
WrData  input  NrOfBits  write data
RdAddrA  input  AddrBits  read address, port A
RdAddrB  input  AddrBits  read address, port B
RdDataA  output  NrOfBits  read data, port A (combinational)
RdDataB  output  NrOfBits  read data, port B (combinational)
Ready  output  1  1 = init sweep finished, writes accepted

Behaviour:
- Clocking and reset: one clock, Clock. Reset is synchronous and active-low: sampled only on the Clock rising edge while low.
- States: INIT, RUN. Registered init_ptr (AddrBits wide) and registered Ready.
- Reset low at an edge: state<=INIT, init_ptr<=0, Ready<=0. This applies from any state, including mid-sweep and mid-RUN.
- INIT, each edge with Reset high:
  - mem[init_ptr]<=0 and init_ptr<=init_ptr+1.
  - Sweep ignores ClockEnable/Tick.
  - When init_ptr==NrOfRegs-1: state<=RUN, Ready<=1.
  - Ready is therefore high NrOfRegs edges after the first edge with Reset high.
- INIT write port: WrEn is ignored entirely; there is no queuing.
- INIT reads: both read outputs return 0 (when cs=0), regardless of array contents.
- RUN: mem[WrAddr]<=WrData at the edge when all of the following hold:
  - WrEn & ClockEnable & Tick
  - WrAddr < NrOfRegs
  - not (ZeroReg==1 and WrAddr==0)
  Otherwise the write is silently dropped.
- Reads, asynchronous, RUN only: RdDataX = mem[RdAddrX]. Returns 0 if RdAddrX >= NrOfRegs, or if ZeroReg==1 and RdAddrX==0.
- Same-address read and write in the same cycle: the read returns the old value until the edge, unless REGFILE_BYPASS_EN is defined.
- cs=1: both read outputs are all-Z. Ready and the write path are unaffected by cs.
- Output values while Reset is held low: Ready=0; RdDataA/RdDataB=0 (cs=0) or Z (cs=1).
- Array contents are undefined before the first sweep completes; they are never observable because INIT masks reads.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: in RUN, if the write is qualified this cycle (all write conditions above true) and RdAddrX==WrAddr, then RdDataX=WrData combinationally. The forward is per port, so A and B are forwarded independently.
- Not defined: no forwarding; reads see pre-edge contents.
- In both cases the zero-register and out-of-range rules take priority over forwarding.

Decomposition:
- Shared package regfile_pkg:
  - state enum (INIT=1'b0, RUN=1'b1)
  - default-width constants (REGFILE_DATA_W=32, REGFILE_REGS=32, REGFILE_ADDR_W=5)
- One sub-module, regfile_init_ctrl. It owns the INIT/RUN FSM, init_ptr and Ready, and outputs init_we and init_addr to the array mux.
- register_file_bank contains: the array, write qualification, write-port mux (init vs. user), read muxing, bypass and tri-state.

Test Plan:
- Reset low 2 cycles then high, NrOfRegs=32 -> Ready=0 for 32 edges, 1 after the 32nd; RdDataA=0 for all addresses during INIT; WrEn=1 to addr 5 during INIT leaves mem[5]=0 after Ready.
- RUN, ClockEnable=1, Tick=1, write 0xDEADBEEF to addr 7 -> RdDataA(addr 7)=0xDEADBEEF the cycle after the edge. Repeat with Tick=0 -> value unchanged.
- ZeroReg=1, write 0x12345678 to addr 0 -> RdDataA/B(addr 0)=0. With ZeroReg=0 -> reads 0x12345678.
- NrOfRegs=24, AddrBits=5, write to addr 30 -> dropped; read of addr 30 returns 0; all regs 0..23 unchanged.
- cs=1 while reading addr 7 -> RdDataA/B all-Z; deassert cs -> 0xDEADBEEF returns; Ready stays 1.
- Reset low for 1 cycle mid-RUN after writing regs 1..31 -> Ready=0 next edge, full 32-cycle sweep, then all registers read 0. With REGFILE_BYPASS_EN, same-cycle write/read of addr 9 with 0xA5A5A5A5 -> RdDataA=0xA5A5A5A5 before the edge; without the macro -> old value.
